// File: rtl/cnn_pkg.sv
// Shared definitions for the MNIST CNN datapath: pixel width, conv2 and
// pooled map dimensions, and the signed pixel type.
`timescale 1ns/1ps
package cnn_pkg;
  localparam int CONV_BIT = 12;
  localparam int CONV2_W  = 8;
  localparam int CONV2_H  = 8;
  localparam int POOL_W   = 4;
  localparam int POOL_H   = 4;

  typedef logic signed [CONV_BIT-1:0] pixel_t;
endpackage

// File: rtl/maxpool_relu_lane.sv
// One channel of the 2x2 max-pool + ReLU: horizontal hold register, a
// half-width row buffer of pair maxima, and the registered output.
`timescale 1ns/1ps
module maxpool_relu_lane
  import cnn_pkg::*;
#(
  parameter int CONV_BIT       = cnn_pkg::CONV_BIT,
  parameter int HALF_WIDTH     = POOL_W,
  parameter int HALF_WIDTH_BIT = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       store_hold,
  input  logic                       store_row,
  input  logic                       emit,
  input  logic [HALF_WIDTH_BIT-1:0]  idx,
  input  logic signed [CONV_BIT-1:0] pixel,
  output logic signed [CONV_BIT-1:0] max_value
);

  function automatic logic signed [CONV_BIT-1:0] smax(
    input logic signed [CONV_BIT-1:0] a,
    input logic signed [CONV_BIT-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [CONV_BIT-1:0] relu(
    input logic signed [CONV_BIT-1:0] a
  );
    return a[CONV_BIT-1] ? '0 : a;
  endfunction

  logic signed [CONV_BIT-1:0] hold_p0;
  logic signed [CONV_BIT-1:0] rowbuf_p0 [HALF_WIDTH];
  logic signed [CONV_BIT-1:0] max_value_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_p0      <= '0;
      max_value_p1 <= '0;
      for (int i = 0; i < HALF_WIDTH; i++) rowbuf_p0[i] <= '0;
    end else begin
      if (store_hold) hold_p0 <= pixel;
      if (store_row)  rowbuf_p0[idx] <= smax(hold_p0, pixel);
      // Odd-row beat closes the 2x2 window: combine with the even-row pair max
      if (emit)       max_value_p1 <= relu(smax(smax(hold_p0, pixel), rowbuf_p0[idx]));
    end
  end

  assign max_value = max_value_p1;

endmodule

// File: rtl/maxpool_relu_2.sv
// Second pooling stage: shared raster counters and phase decode driving three
// lockstep max-pool/ReLU lanes, 8x8 in -> 4x4 out per channel.
`timescale 1ns/1ps
module maxpool_relu_2
  import cnn_pkg::*;
#(
  parameter int CONV_BIT       = cnn_pkg::CONV_BIT,
  parameter int HALF_WIDTH     = POOL_W,
  parameter int HALF_HEIGHT    = POOL_H,
  parameter int HALF_WIDTH_BIT = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic signed [CONV_BIT-1:0] conv_out_1,
  input  logic signed [CONV_BIT-1:0] conv_out_2,
  input  logic signed [CONV_BIT-1:0] conv_out_3,
  output logic signed [CONV_BIT-1:0] max_value_1,
  output logic signed [CONV_BIT-1:0] max_value_2,
  output logic signed [CONV_BIT-1:0] max_value_3,
  output logic                       valid_out_relu
);

  localparam int COL_W = HALF_WIDTH_BIT + 1;
  localparam int ROW_W = $clog2(2 * HALF_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(2 * HALF_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(2 * HALF_HEIGHT - 1);

  logic [COL_W-1:0]          col;
  logic [ROW_W-1:0]          row;
  logic                      store_hold, store_row, emit;
  logic [HALF_WIDTH_BIT-1:0] idx;
  logic                      vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (valid_in) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Phase decode: even col fills hold, odd col on even row fills rowbuf,
  // odd col on odd row completes a window.
  assign store_hold = valid_in & ~col[0];
  assign store_row  = valid_in &  col[0] & ~row[0];
  assign emit       = valid_in &  col[0] &  row[0];
  assign idx        = col[HALF_WIDTH_BIT:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= emit;
  end

  assign valid_out_relu = vld_p1;

  maxpool_relu_lane #(
    .CONV_BIT(CONV_BIT), .HALF_WIDTH(HALF_WIDTH), .HALF_WIDTH_BIT(HALF_WIDTH_BIT)
  ) u_lane_1 (
    .clk(clk), .rst_n(rst_n), .store_hold(store_hold), .store_row(store_row),
    .emit(emit), .idx(idx), .pixel(conv_out_1), .max_value(max_value_1)
  );

  maxpool_relu_lane #(
    .CONV_BIT(CONV_BIT), .HALF_WIDTH(HALF_WIDTH), .HALF_WIDTH_BIT(HALF_WIDTH_BIT)
  ) u_lane_2 (
    .clk(clk), .rst_n(rst_n), .store_hold(store_hold), .store_row(store_row),
    .emit(emit), .idx(idx), .pixel(conv_out_2), .max_value(max_value_2)
  );

  maxpool_relu_lane #(
    .CONV_BIT(CONV_BIT), .HALF_WIDTH(HALF_WIDTH), .HALF_WIDTH_BIT(HALF_WIDTH_BIT)
  ) u_lane_3 (
    .clk(clk), .rst_n(rst_n), .store_hold(store_hold), .store_row(store_row),
    .emit(emit), .idx(idx), .pixel(conv_out_3), .max_value(max_value_3)
  );

endmodule

// File: tb/tb_maxpool_relu_2.sv
// Scoreboard bench for maxpool_relu_2: a frame-level reference model pushes
// expected pooled pixels and pulse times; a monitor pops on each valid pulse.
`timescale 1ns/1ps
module tb_maxpool_relu_2;
  import cnn_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_in = 1'b0;
  logic signed [11:0] c1 = '0, c2 = '0, c3 = '0;
  logic signed [11:0] m1, m2, m3;
  logic vout;

  always #5 clk = ~clk;

  maxpool_relu_2 dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .conv_out_1(c1), .conv_out_2(c2), .conv_out_3(c3),
    .max_value_1(m1), .max_value_2(m2), .max_value_3(m3),
    .valid_out_relu(vout)
  );

  typedef struct {
    int     v [3];
    longint t;
  } exp_t;

  exp_t q[$];
  int   fr [3][64];
  int   k = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: max of the 2x2 window ending at (r,c) of the current frame, then ReLU
  function automatic int pool(input int ch, input int r, input int c);
    int m;
    m = fr[ch][(r-1)*8 + c-1];
    if (fr[ch][(r-1)*8 + c] > m) m = fr[ch][(r-1)*8 + c];
    if (fr[ch][r*8 + c-1]   > m) m = fr[ch][r*8 + c-1];
    if (fr[ch][r*8 + c]     > m) m = fr[ch][r*8 + c];
    return (m < 0) ? 0 : m;
  endfunction

  task automatic send(input int p1, input int p2, input int p3, input int gap);
    logic signed [11:0] s [3];
    int p [3];
    int r, c;
    exp_t e;
    p[0] = p1; p[1] = p2; p[2] = p3;
    repeat (gap) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
    @(negedge clk);
    for (int ch = 0; ch < 3; ch++) begin
      s[ch] = p[ch][11:0];
      fr[ch][k] = int'(s[ch]);
    end
    c1 = s[0]; c2 = s[1]; c3 = s[2];
    valid_in = 1'b1;
    r = k / 8;
    c = k % 8;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      for (int ch = 0; ch < 3; ch++) e.v[ch] = pool(ch, r, c);
      e.t = longint'($time) + 10;
      q.push_back(e);
    end
    k = (k + 1) % 64;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
  endtask

  task automatic ramp(input int maxgap);
    for (int i = 0; i < 64; i++) send(i, i, i, $urandom_range(0, maxgap));
  endtask

  always @(negedge clk) begin
    if (rst_n && vout) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("ch1_value", longint'(m1), e.v[0]);
        check("ch2_value", longint'(m2), e.v[1]);
        check("ch3_value", longint'(m3), e.v[2]);
        check("pulse_time", longint'($time), e.t);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset state
    #12;
    check("rst_max1", longint'(m1), 0);
    check("rst_max2", longint'(m2), 0);
    check("rst_max3", longint'(m3), 0);
    check("rst_valid", longint'(vout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    ramp(0);
    idle(3);

    // Asynchronous mid-cycle reset must clear outputs before any clock edge
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_max1", longint'(m1), 0);
    check("async_max2", longint'(m2), 0);
    check("async_max3", longint'(m3), 0);
    check("async_valid", longint'(vout), 0);
    k = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    for (int i = 0; i < 64; i++) send(-5, -5, -5, 0);

    for (int i = 0; i < 64; i++) begin
      case (i)
        0:       send(12'h800, 12'hF00, 12'h800, 0);
        1:       send(12'h7FF, 12'hFF0, 12'h7FF, 0);
        8:       send(12'h001, 12'hFFE, 12'h001, 0);
        9:       send(12'hFFF, 12'hFFF, 12'hFFF, 0);
        default: send($urandom, $urandom, $urandom, 0);
      endcase
    end

    ramp(3);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 64; i++) send($urandom, $urandom, $urandom, $urandom_range(0, 2));
    idle(3);

    // Abort a frame after 20 pixels, then two fresh back-to-back frames
    for (int i = 0; i < 20; i++) send(i, i, i, 0);
    idle(2);
    rst_n = 1'b0;
    k = 0;
    idle(2);
    rst_n = 1'b1;
    ramp(0);
    ramp(0);
    idle(4);

    check("drain_empty", longint'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
